// File: rtl/scr1_tcm_dmem_bridge.sv
// -----------------------------------------------------------------------------
// scr1_tcm_dmem_bridge
//   Connects the LSU dmem request/response handshake to port B of the dual-port
//   TCM RAM. It generates byte enables and lane-shifted write data, returns read
//   data aligned to the LSBs one cycle after acceptance, and answers misaligned,
//   invalid-width and out-of-range requests with an error that never reaches
//   the RAM.
//
//   Build option: SCR1_TCM_MISALIGN_ERR_EN
//     defined   - misaligned halfword/word accesses get an error response.
//     undefined - the offset is truncated to the access width, and the access
//                 proceeds on the aligned location with an OK response.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module scr1_tcm_dmem_bridge #(
    parameter int          SCR1_WIDTH  = 32,
    parameter logic [31:0] SCR1_SIZE   = 32'h00010000,
    parameter int          SCR1_AWIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           dmem_req,
    input  logic                           dmem_cmd,
    input  logic [1:0]                     dmem_width,
    input  logic [SCR1_AWIDTH-1:0]         dmem_addr,
    input  logic [SCR1_WIDTH-1:0]          dmem_wdata,
    output logic                           dmem_req_ack,
    output logic [SCR1_WIDTH-1:0]          dmem_rdata,
    output logic [1:0]                     dmem_resp,
    output logic                           mem_ren,
    output logic                           mem_wen,
    output logic [3:0]                     mem_web,
    output logic [$clog2(SCR1_SIZE)-3:0]   mem_addr,
    output logic [SCR1_WIDTH-1:0]          mem_wdata,
    input  logic [SCR1_WIDTH-1:0]          mem_rdata
);

    localparam int                     IDX_MSB = $clog2(SCR1_SIZE) - 1;
    localparam logic [SCR1_AWIDTH-1:0] SIZE_A  = SCR1_AWIDTH'(SCR1_SIZE);

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'b00,
        RESP_OK_RD = 2'b01,
        RESP_OK_WR = 2'b10,
        RESP_ERR   = 2'b11
    } resp_state_e;

    resp_state_e resp_state_q, resp_state_d;
    logic [1:0]  off_q, off_d;
    logic [1:0]  width_q, width_d;

    logic        req_acc_s;
    logic [1:0]  off_raw_s;
    logic [1:0]  off_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic        invalid_s;
    logic        err_s;
    logic        mem_drive_s;
    logic [SCR1_WIDTH-1:0] rd_shift_s;

    // The bridge can always take a request; it only refuses while held in reset.
    assign dmem_req_ack = rst_n;
    assign req_acc_s    = dmem_req & dmem_req_ack;

    // Decode the request: byte offset, error classes and whether the RAM is driven.
    always_comb begin
        off_raw_s      = dmem_addr[1:0];
        invalid_s      = (dmem_width == 2'b11);
        out_of_range_s = (dmem_addr >= SIZE_A);
`ifdef SCR1_TCM_MISALIGN_ERR_EN
        off_s          = off_raw_s;
        misaligned_s   = ((dmem_width == 2'b01) && off_raw_s[0]) ||
                         ((dmem_width == 2'b10) && (off_raw_s != 2'b00));
`else
        misaligned_s   = 1'b0;
        case (dmem_width)
            2'b01:   off_s = {off_raw_s[1], 1'b0};
            2'b10:   off_s = 2'b00;
            default: off_s = off_raw_s;
        endcase
`endif
        err_s          = misaligned_s | out_of_range_s | invalid_s;
        mem_drive_s    = req_acc_s & ~err_s;
    end

    // RAM port-B controls; everything stays at zero unless a good request is accepted.
    always_comb begin
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        mem_web   = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_drive_s) begin
            mem_ren   = ~dmem_cmd;
            mem_wen   = dmem_cmd;
            mem_addr  = dmem_addr[IDX_MSB:2];
            mem_wdata = dmem_wdata << {off_s, 3'b000};
            case (dmem_width)
                2'b00:   mem_web = 4'b0001 << off_s;
                2'b01:   mem_web = 4'b0011 << off_s;
                default: mem_web = 4'b1111;
            endcase
        end else begin
            mem_ren   = 1'b0;
            mem_wen   = 1'b0;
            mem_web   = 4'b0000;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // Next response slot: each acceptance is answered in the following cycle.
    always_comb begin
        resp_state_d = RESP_IDLE;
        off_d        = off_q;
        width_d      = width_q;
        if (req_acc_s) begin
            off_d   = off_s;
            width_d = dmem_width;
            if (err_s) begin
                resp_state_d = RESP_ERR;
            end else if (dmem_cmd) begin
                resp_state_d = RESP_OK_WR;
            end else begin
                resp_state_d = RESP_OK_RD;
            end
        end else begin
            resp_state_d = RESP_IDLE;
        end
    end

    // Response slot registers; reset drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_state_q <= RESP_IDLE;
            off_q        <= 2'b00;
            width_q      <= 2'b00;
        end else begin
            resp_state_q <= resp_state_d;
            off_q        <= off_d;
            width_q      <= width_d;
        end
    end

    // Response outputs: read data shifted down to the LSBs and zero-extended.
    always_comb begin
        rd_shift_s = mem_rdata >> {off_q, 3'b000};
        dmem_resp  = 2'b00;
        dmem_rdata = '0;
        case (resp_state_q)
            RESP_OK_RD: begin
                dmem_resp = 2'b01;
                case (width_q)
                    2'b00:   dmem_rdata[7:0]  = rd_shift_s[7:0];
                    2'b01:   dmem_rdata[15:0] = rd_shift_s[15:0];
                    2'b10:   dmem_rdata       = rd_shift_s;
                    default: dmem_rdata       = '0;
                endcase
            end
            RESP_OK_WR: dmem_resp = 2'b01;
            RESP_ERR:   dmem_resp = 2'b10;
            default: begin
                dmem_resp  = 2'b00;
                dmem_rdata = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_scr1_tcm_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_scr1_tcm_dmem_bridge
//   Scoreboard bench: the driver computes the expected response from a
//   byte-array memory model and queues it, together with the cycle in which it
//   is due; a negedge monitor compares whatever the bridge presents.
//   A word-wide RAM with a registered read port stands in for TCM port B.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_scr1_tcm_dmem_bridge;

`ifdef SCR1_TCM_MISALIGN_ERR_EN
    localparam bit MIS_ERR = 1'b1;
`else
    localparam bit MIS_ERR = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        dmem_req;
    logic        dmem_cmd;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_req_ack;
    logic [31:0] dmem_rdata;
    logic [1:0]  dmem_resp;
    logic        mem_ren;
    logic        mem_wen;
    logic [3:0]  mem_web;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    typedef struct {
        int          due;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem [0:65535];
    logic [31:0] ram [0:16383];
    int          cyc;
    int          errors;
    int          checks;

    scr1_tcm_dmem_bridge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dmem_req     (dmem_req),
        .dmem_cmd     (dmem_cmd),
        .dmem_width   (dmem_width),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_req_ack (dmem_req_ack),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_ren      (mem_ren),
        .mem_wen      (mem_wen),
        .mem_web      (mem_web),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TCM port B: byte-enabled write, registered read.
    always @(posedge clk) begin
        if (mem_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_web[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_ren) mem_rdata <= ram[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare the due response, otherwise the bridge must be silent.
    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            chk("resp", 32'(dmem_resp), 32'(exp_q[0].resp));
            chk("rdata", dmem_rdata, exp_q[0].rdata);
            void'(exp_q.pop_front());
        end else if (dmem_resp !== 2'b00 || dmem_rdata !== 32'h0) begin
            chk("idle_resp", {dmem_rdata[29:0], dmem_resp}, 32'h0);
        end
    end

    // Drive one request; expectations come from the byte-array model.
    task automatic issue(input logic cmd, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int          n;
        logic        err;
        logic [31:0] eff;
        logic [31:0] rd;
        logic [3:0]  ew;
        logic [31:0] ewd;
        @(posedge clk);
        #1;
        dmem_req   = 1'b1;
        dmem_cmd   = cmd;
        dmem_width = w;
        dmem_addr  = a;
        dmem_wdata = d;
        n   = 1 << int'(w);
        err = (w == 2'b11) || (a >= 32'h00010000) || (MIS_ERR && ((a % n) != 0));
        eff = a - (a % n);
        e.due   = cyc + 1;
        e.resp  = 2'b01;
        e.rdata = 32'h0;
        if (err) begin
            e.resp = 2'b10;
        end else if (cmd) begin
            for (int i = 0; i < n; i++) ref_mem[eff + i] = d[8*i +: 8];
        end else begin
            rd = 32'h0;
            for (int i = 0; i < n; i++) rd = rd | (32'(ref_mem[eff + i]) << (8*i));
            e.rdata = rd;
        end
        exp_q.push_back(e);
        ew  = err ? 4'b0000 : 4'(((1 << n) - 1) << (eff % 4));
        ewd = err ? 32'h0 : (d << (8*(eff % 4)));
        #1;
        chk("mem_ren", 32'(mem_ren), 32'(!err && !cmd));
        chk("mem_wen", 32'(mem_wen), 32'(!err && cmd));
        chk("mem_web", 32'(mem_web), 32'(ew));
        chk("mem_wdata", mem_wdata, ewd);
        chk("mem_addr", 32'(mem_addr), err ? 32'h0 : 32'(eff[15:2]));
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        dmem_req   = 1'b0;
        dmem_cmd   = 1'($urandom);
        dmem_width = 2'($urandom);
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
        #1;
        chk("idle_mem", {mem_wdata[26:0], mem_web, mem_wen}, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, time %0t expected below 2000000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [31:0] a;
        errors    = 0;
        checks    = 0;
        cyc       = 0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
        for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
        rst_n      = 1'b0;
        dmem_req   = 1'b1;
        dmem_cmd   = 1'b0;
        dmem_width = 2'b10;
        dmem_addr  = 32'h20;
        dmem_wdata = 32'h0;
        #3;
        chk("rst_ack", 32'(dmem_req_ack), 32'h0);
        chk("rst_resp", 32'(dmem_resp), 32'h0);
        chk("rst_rdata", dmem_rdata, 32'h0);
        chk("rst_mem_ren", 32'(mem_ren), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        dmem_req = 1'b0;
        #1;
        chk("ack_after_rst", 32'(dmem_req_ack), 32'h1);

        // Directed cases.
        issue(1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 2'b10, 32'h10, 32'h0);
        issue(1'b1, 2'b00, 32'h13, 32'h000000A5);
        issue(1'b0, 2'b00, 32'h13, 32'h0);
        issue(1'b1, 2'b10, 32'h10, 32'h11223344);
        issue(1'b0, 2'b01, 32'h12, 32'h0);
        issue(1'b0, 2'b01, 32'h11, 32'h0);
        issue(1'b0, 2'b10, 32'h00010000, 32'h0);
        issue(1'b1, 2'b11, 32'h20, 32'h55AA55AA);
        issue(1'b0, 2'b10, 32'h10, 32'h0);
        idle();

        // Random traffic around a small window plus out-of-range addresses.
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 15);
            if (r == 0)      a = 32'h00010000 + $urandom_range(0, 255);
            else if (r == 1) a = $urandom;
            else             a = $urandom_range(0, 127);
            issue(1'($urandom), 2'($urandom_range(0, 3)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle();
        end

        // Reset between acceptance and response: the response is dropped.
        issue(1'b0, 2'b10, 32'h10, 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        chk("midrst_resp", 32'(dmem_resp), 32'h0);
        chk("midrst_rdata", dmem_rdata, 32'h0);
        chk("midrst_ack", 32'(dmem_req_ack), 32'h0);
        chk("midrst_mem_ren", 32'(mem_ren), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        dmem_req = 1'b0;
        issue(1'b0, 2'b10, 32'h10, 32'h0);
        issue(1'b0, 2'b00, 32'h13, 32'h0);
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
